// File: rtl/apple2_bus_pkg.sv
// Shared phase encoding and slot address decode for the Apple II slot bus master.
// Consumed by apple2_bus_timer and apple2_slot_master.
package apple2_bus_pkg;

    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, T7, T8} phase_t;

    localparam phase_t      PHI1_LAST   = T3;
    localparam phase_t      DOE_FIRST   = T5;
    localparam logic [11:0] DEVSEL_BASE = 12'hC08;
    localparam logic [7:0]  IOSEL_BASE  = 8'hC0;
    localparam logic [4:0]  IOSTRB_BASE = 5'b11001;

    function automatic logic is_devsel(input logic [2:0] slot, input logic [15:0] a);
        return a[15:4] == (DEVSEL_BASE + {9'd0, slot});
    endfunction

    function automatic logic is_iosel(input logic [2:0] slot, input logic [15:0] a);
        return a[15:8] == (IOSEL_BASE + {5'd0, slot});
    endfunction

    function automatic logic is_iostrb(input logic [15:0] a);
        return a[15:11] == IOSTRB_BASE;
    endfunction

endpackage

// File: rtl/apple2_bus_timer.sv
// Bus cycle phase sequencer T1..T7, with an optional T8 every 65th cycle
// when TIMEMACHINE_LONGCYCLE_EN is defined.
module apple2_bus_timer
    import apple2_bus_pkg::*;
(
    input  logic       C7M,
    input  logic       nRES,
    output logic [2:0] phase,
    output logic       phi1,
    output logic       last_phase
);

    phase_t cur;
    logic   long_now;

    assign phase = cur;

`ifdef TIMEMACHINE_LONGCYCLE_EN
    localparam logic [6:0] LONG_CYCLE = 7'd64;
    logic [6:0] cyc_cnt;

    assign long_now = (cyc_cnt == LONG_CYCLE);

    // Counter advances as each cycle closes, so it names the cycle in progress.
    always_ff @(posedge C7M) begin
        if (!nRES)
            cyc_cnt <= '0;
        else if (last_phase)
            cyc_cnt <= long_now ? 7'd0 : cyc_cnt + 7'd1;
    end
`else
    assign long_now = 1'b0;
`endif

    // phi1 and last_phase are registered for the phase being entered.
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            cur        <= T1;
            phi1       <= 1'b1;
            last_phase <= 1'b0;
        end else begin
            case (cur)
                T6: begin
                    cur        <= T7;
                    phi1       <= 1'b0;
                    last_phase <= !long_now;
                end
                T7: begin
                    if (long_now) begin
                        cur        <= T8;
                        phi1       <= 1'b0;
                        last_phase <= 1'b1;
                    end else begin
                        cur        <= T1;
                        phi1       <= 1'b1;
                        last_phase <= 1'b0;
                    end
                end
                T8: begin
                    cur        <= T1;
                    phi1       <= 1'b1;
                    last_phase <= 1'b0;
                end
                default: begin
                    cur        <= phase_t'(cur + 3'd1);
                    phi1       <= (cur < PHI1_LAST);
                    last_phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apple2_slot_master.sv
// Apple II slot bus initiator: request capture, strobe decode, data path and read response.
// Long cycles (T8 every 65th cycle) are enabled by TIMEMACHINE_LONGCYCLE_EN.
module apple2_slot_master
    import apple2_bus_pkg::*;
#(
    parameter int          SLOT      = 1,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic        C7M,
    input  logic        nRES,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        PHI1,
    output logic [15:0] A,
    output logic        nWE,
    output logic [7:0]  Dout,
    output logic        Doe,
    input  logic [7:0]  Din,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB
);

    localparam logic [2:0] SLOT_ID = 3'(SLOT);

    logic [2:0] phase;
    logic       last_phase;
    phase_t     ph;
    logic       cur_rd, cur_wr, cur_dev, cur_ios, cur_strb;

    apple2_bus_timer u_timer (
        .C7M        (C7M),
        .nRES       (nRES),
        .phase      (phase),
        .phi1       (PHI1),
        .last_phase (last_phase)
    );

    assign ph        = phase_t'(phase);
    assign req_ready = last_phase;

    always_ff @(posedge C7M) begin
        if (!nRES) begin
            A         <= IDLE_ADDR;
            nWE       <= 1'b1;
            nDEVSEL   <= 1'b1;
            nIOSEL    <= 1'b1;
            nIOSTRB   <= 1'b1;
            Doe       <= 1'b0;
            Dout      <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            cur_rd    <= 1'b0;
            cur_wr    <= 1'b0;
            cur_dev   <= 1'b0;
            cur_ios   <= 1'b0;
            cur_strb  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (last_phase) begin
                // Closing edge of the cycle: finish the old access, launch the next.
                if (cur_rd) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= Din;
                end
                A        <= req_valid ? req_addr : IDLE_ADDR;
                nWE      <= !(req_valid && req_we);
                cur_rd   <= req_valid && !req_we;
                cur_wr   <= req_valid && req_we;
                cur_dev  <= req_valid && is_devsel(SLOT_ID, req_addr);
                cur_ios  <= req_valid && is_iosel(SLOT_ID, req_addr);
                cur_strb <= req_valid && is_iostrb(req_addr);
                if (req_valid && req_we)
                    Dout <= req_wdata;
                nDEVSEL  <= 1'b1;
                nIOSEL   <= 1'b1;
                nIOSTRB  <= 1'b1;
                Doe      <= 1'b0;
            end else if (ph == PHI1_LAST) begin
                nDEVSEL <= !cur_dev;
                nIOSEL  <= !cur_ios;
                nIOSTRB <= !cur_strb;
            end else if (ph == phase_t'(DOE_FIRST - 3'd1)) begin
                Doe <= cur_wr;
            end
        end
    end

endmodule

// File: tb/tb_apple2_slot_master.sv
// Self-checking bench for apple2_slot_master: a phase-level reference model checks every
// clock, and a response scoreboard checks read data whenever rsp_valid is presented.
`timescale 1ns/1ps
module tb_apple2_slot_master;

    localparam int          SLOT = 3;
    localparam logic [15:0] IDLE = 16'h0000;
`ifdef TIMEMACHINE_LONGCYCLE_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    logic        C7M = 1'b0;
    logic        nRES = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic [7:0]  Din = 8'h00;
    logic        req_ready, rsp_valid, PHI1, nWE, Doe, nDEVSEL, nIOSEL, nIOSTRB;
    logic [7:0]  rsp_rdata, Dout;
    logic [15:0] A;

    apple2_slot_master #(.SLOT(SLOT), .IDLE_ADDR(IDLE)) dut (
        .C7M       (C7M),
        .nRES      (nRES),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .PHI1      (PHI1),
        .A         (A),
        .nWE       (nWE),
        .Dout      (Dout),
        .Doe       (Doe),
        .Din       (Din),
        .nDEVSEL   (nDEVSEL),
        .nIOSEL    (nIOSEL),
        .nIOSTRB   (nIOSTRB)
    );

    always #5 C7M = ~C7M;

    // strb: 0 none, 1 nDEVSEL, 2 nIOSEL, 3 nIOSTRB (hand-decoded for SLOT = 3)
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
        logic [1:0]  strb;
        logic        act;
    } req_t;

    req_t       req_q[$];
    logic [7:0] rsp_q[$];
    int         rsp_clk[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances one phase per clock, sampled on the falling edge.
    int   tb_ph = 1, tb_len = 7, cyc = 0, clk_n = 0;
    logic nres_next = 1'b0, cap_next = 1'b0, prev_rd = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    req_t cur = '{16'h0000, 1'b0, 8'h00, 2'd0, 1'b0};

    always @(negedge C7M) begin
        clk_n++;
        if (!nres_next) begin
            tb_ph    = 1;
            tb_len   = 7;
            cyc      = 0;
            prev_rd  = 1'b0;
            exp_dout = 8'h00;
            cur      = '{IDLE, 1'b0, 8'h00, 2'd0, 1'b0};
        end else if (tb_ph == tb_len) begin
            prev_rd = cur.act && !cur.we;
            cyc++;
            tb_len  = (LONG && (cyc % 65 == 64)) ? 8 : 7;
            tb_ph   = 1;
            cur     = '{IDLE, 1'b0, 8'h00, 2'd0, 1'b0};
            if (cap_next) begin
                chk("req_queue_nonempty", req_q.size() != 0, 1);
                if (req_q.size() != 0)
                    cur = req_q.pop_front();
            end
            if (cur.act && cur.we)
                exp_dout = cur.data;
            Din = (cur.act && !cur.we) ? cur.data : 8'hFF;
        end else begin
            tb_ph++;
        end

        chk("PHI1",      PHI1,      tb_ph <= 3);
        chk("req_ready", req_ready, tb_ph == tb_len);
        chk("A",         A,         cur.act ? cur.addr : IDLE);
        chk("nWE",       nWE,       !(cur.act && cur.we));
        chk("nDEVSEL",   nDEVSEL,   !(tb_ph >= 4 && cur.strb == 2'd1));
        chk("nIOSEL",    nIOSEL,    !(tb_ph >= 4 && cur.strb == 2'd2));
        chk("nIOSTRB",   nIOSTRB,   !(tb_ph >= 4 && cur.strb == 2'd3));
        chk("Doe",       Doe,       cur.act && cur.we && tb_ph >= 5);
        chk("Dout",      Dout,      exp_dout);
        chk("rsp_valid", rsp_valid, tb_ph == 1 && prev_rd);

        if (rsp_valid === 1'b1) begin
            rsp_clk.push_back(clk_n);
            chk("rsp_expected", rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0)
                chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
        end

        nres_next = nRES;
        cap_next  = req_valid && req_ready;
    end

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic do_req(input logic [15:0] addr, input logic we, input logic [7:0] data,
                          input logic [1:0] strb, input bit expect_rsp);
        int n = 0;
        req_addr  = addr;
        req_we    = we;
        req_wdata = we ? data : 8'h00;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge C7M); #2;
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        if (req_ready === 1'b1) begin
            req_q.push_back('{addr, we, data, strb, 1'b1});
            if (!we && expect_rsp)
                rsp_q.push_back(data);
            @(posedge C7M); #2;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge C7M); #2;
        end
    endtask

    initial begin
        int sz;
        int n;
        nRES = 1'b0;
        repeat (3) @(posedge C7M);
        #2 nRES = 1'b1;
        idle(21);

        do_req(16'hC0B3, 1'b1, 8'h5A, 2'd1, 1'b0);   // slot 3 nDEVSEL write
        idle(10);
        do_req(16'hC300, 1'b0, 8'hA7, 2'd2, 1'b1);   // slot 3 nIOSEL read
        idle(10);
        do_req(16'hCFFF, 1'b0, 8'h3C, 2'd3, 1'b1);   // back-to-back nIOSTRB reads
        do_req(16'hC800, 1'b0, 8'hC3, 2'd3, 1'b1);
        idle(20);
        sz = rsp_clk.size();
        chk("rsp_count_after_b2b", sz, 3);
        if (sz >= 2)
            chk("b2b_rsp_gap", rsp_clk[sz-1] - rsp_clk[sz-2], 7);

        do_req(16'hC0A3, 1'b1, 8'h11, 2'd0, 1'b0);   // slot 2 window: no strobe
        do_req(16'hC400, 1'b0, 8'h42, 2'd0, 1'b1);   // slot 4 page: no strobe, still a read
        idle(10);

        // Read aborted by reset during T5: no response may follow.
        do_req(16'hC3FF, 1'b0, 8'h99, 2'd2, 1'b0);
        n = 0;
        while (tb_ph != 4 && n < 20) begin
            @(posedge C7M); #2;
            n++;
        end
        chk("abort_phase_reached", tb_ph, 4);
        nRES = 1'b0;
        repeat (3) @(posedge C7M);
        #2 nRES = 1'b1;
        idle(3);
        chk("rsp_count_after_abort", rsp_clk.size(), 4);

        do_req(16'hC300, 1'b0, 8'h5E, 2'd2, 1'b1);   // recovery read
        idle(135 * 7 + 10);                          // spans cycles 64 and 129

        chk("rsp_count_final", rsp_clk.size(), 5);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
